// File: rtl/adc_resp_pkg.sv
// Shared types and frame geometry for the ADC SPI responder model.
// Frame = LEAD_ZEROS zero bits followed by a DATA_W conversion, MSB first.
package adc_resp_pkg;

    localparam int N_CH       = 8;
    localparam int CH_W       = 3;
    localparam int DATA_W     = 12;
    localparam int LEAD_ZEROS = 4;
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int ADDR_HI    = 13;
    localparam int ADDR_LO    = 11;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    function automatic logic [FRAME_BITS-1:0] pad_sample(input logic [DATA_W-1:0] sample);
        return {{LEAD_ZEROS{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into the clk domain and flags
// rising/falling edges of cs_n and sclk. SYNC_STAGES must be at least 2.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic cs_n,
    input  logic sclk,
    input  logic din,
    output logic cs_n_s,
    output logic din_s,
    output logic cs_fall,
    output logic cs_rise,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   cs_prev;
    logic                   sclk_prev;

    // NOTE: these flops are deliberately not reset; they keep tracking the pins through
    // reset, so releasing reset never fabricates an edge from a forced reset value.
    always_ff @(posedge clk) begin
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
        cs_prev   <= cs_sync[SYNC_STAGES-1];
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise   = ~cs_prev & cs_sync[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-3 responder modelling the 8-channel 12-bit ADC (pipelined channel select).
// Optional ADC_RESP_RAMP_EN: each completed frame increments the served channel's value.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        din,
    output logic        dout,
    input  logic        ch_wr_en,
    input  logic [2:0]  ch_wr_addr,
    input  logic [11:0] ch_wr_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  last_addr
);

    logic cs_n_s;
    logic din_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .din      (din),
        .cs_n_s   (cs_n_s),
        .din_s    (din_s),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall)
    );

    state_t                  state;
    logic [FRAME_BITS-2:0]   shreg;      // bits still to send; the MSB is already on dout
    logic [ADDR_HI-1:0]      rx;         // only the bits that can still reach the address field
    logic [4:0]              bit_cnt;
    logic                    seen_rise;
    logic                    armed;      // cs_n seen high since reset
    logic [CH_W-1:0]         next_ch;
    logic [DATA_W-1:0]       bank [N_CH];
    logic [FRAME_BITS-1:0]   load_word;
    logic                    frame_start;
    logic                    frame_complete;

    assign load_word      = pad_sample(bank[next_ch]);
    assign frame_start    = (state == IDLE) && cs_fall && armed;
    assign frame_complete = (state == ACTIVE) && !cs_rise && sclk_rise
                            && (bit_cnt == 5'(FRAME_BITS - 1));

    // NOTE: non-blocking updates only, so every branch and the bank logic see pre-edge
    // values; the ramp below relies on next_ch still naming the served channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            seen_rise  <= 1'b0;
            armed      <= 1'b0;
            next_ch    <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            last_addr  <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    dout <= 1'b0;
                    if (cs_n_s)
                        armed <= 1'b1;
                    // sclk edges coinciding with the start are dropped here by construction
                    if (frame_start) begin
                        state     <= ACTIVE;
                        dout      <= load_word[FRAME_BITS-1];
                        shreg     <= load_word[FRAME_BITS-2:0];
                        bit_cnt   <= '0;
                        seen_rise <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        dout      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        rx        <= {rx[ADDR_HI-2:0], din_s};
                        bit_cnt   <= bit_cnt + 5'd1;
                        seen_rise <= 1'b1;
                        if (frame_complete) begin
                            state      <= DONE;
                            dout       <= 1'b0;
                            next_ch    <= rx[ADDR_HI-1:ADDR_LO-1];
                            last_addr  <= rx[ADDR_HI-1:ADDR_LO-1];
                            frame_done <= 1'b1;
                        end
                    end else if (sclk_fall && seen_rise) begin
                        dout  <= shreg[FRAME_BITS-2];
                        shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                    end
                end
                DONE: begin
                    dout <= 1'b0;
                    if (cs_rise)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the bank is a small flop array rather than a RAM, so it is reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++)
                bank[i] <= '0;
        end else begin
`ifdef ADC_RESP_RAMP_EN
            if (frame_complete)
                bank[next_ch] <= bank[next_ch] + DATA_W'(1);
`endif
            // placed last so a same-cycle host write overrides the ramp
            if (ch_wr_en)
                bank[ch_wr_addr] <= ch_wr_data;
        end
    end

endmodule
